// File: rtl/button_pulse_conditioner.sv
// Synchronises, debounces and edge-detects NUM_BTN push-buttons into clean level and strobe outputs.
// Optional macro BTN_AUTOREPEAT_EN adds press auto-repeat while a button stays held.
module button_pulse_conditioner #(
   parameter int NUM_BTN         = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_BTN-1:0] BTN_IN,
   output logic [NUM_BTN-1:0] BTN_STATE,
   output logic [NUM_BTN-1:0] PRESS_PULSE,
   output logic [NUM_BTN-1:0] RELEASE_PULSE
);

   // state        | meaning
   // IDLE         | debounced level 0, input low
   // PRESS_WAIT   | input went high, counting stable-high cycles
   // HELD         | debounced level 1, input high
   // RELEASE_WAIT | input went low, counting stable-low cycles
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } chan_state_t;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("button_pulse_conditioner: DEBOUNCE_CYCLES must be >=2, REPEAT_* >=1");
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCNT_W  = $clog2(RPT_MAX + 1);
   localparam logic [RCNT_W-1:0] RCNT_ONE   = RCNT_W'(1);
   localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
`endif

   logic [NUM_BTN-1:0] sync_meta;
   logic [NUM_BTN-1:0] sync_ff;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync_meta <= '0;
         sync_ff   <= '0;
      end else begin
         sync_meta <= BTN_IN;
         sync_ff   <= sync_meta;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      chan_state_t      state, state_nxt;
      logic [CNT_W-1:0] cnt, cnt_nxt;
      logic             level, level_nxt;
      logic             press_q, press_nxt;
      logic             rel_q, rel_nxt;
      logic             sync_bit;

      assign sync_bit = sync_ff[i];

`ifdef BTN_AUTOREPEAT_EN
      logic [RCNT_W-1:0] rcnt, rcnt_nxt;
      logic              rpt_arm, rpt_arm_nxt;
      logic              rpt_fire;

      // First repeat waits the long delay, later ones use the shorter period.
      assign rpt_fire = rpt_arm ? (rcnt == PERIOD_LAST) : (rcnt == DELAY_LAST);
`endif

      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         level_nxt = level;
         press_nxt = 1'b0;
         rel_nxt   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rcnt_nxt    = '0;
         rpt_arm_nxt = 1'b0;
`endif
         case (state)
            IDLE: begin
               if (sync_bit) begin
                  state_nxt = PRESS_WAIT;
                  cnt_nxt   = CNT_ONE;
               end else begin
                  cnt_nxt   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync_bit) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = HELD;
                  cnt_nxt   = '0;
                  level_nxt = 1'b1;
                  press_nxt = 1'b1;
               end else begin
                  cnt_nxt   = cnt + CNT_ONE;
               end
            end
            HELD: begin
               if (!sync_bit) begin
                  state_nxt = RELEASE_WAIT;
                  cnt_nxt   = CNT_ONE;
               end else begin
`ifdef BTN_AUTOREPEAT_EN
                  if (rpt_fire) begin
                     press_nxt   = 1'b1;
                     rcnt_nxt    = '0;
                     rpt_arm_nxt = 1'b1;
                  end else begin
                     rcnt_nxt    = rcnt + RCNT_ONE;
                     rpt_arm_nxt = rpt_arm;
                  end
`endif
               end
            end
            RELEASE_WAIT: begin
               if (sync_bit) begin
                  state_nxt = HELD;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  level_nxt = 1'b0;
                  rel_nxt   = 1'b1;
               end else begin
                  cnt_nxt   = cnt + CNT_ONE;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
            end
         endcase
      end

      always_ff @(posedge CLK or negedge RESET) begin
         if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            level   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level   <= level_nxt;
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
         end
      end

`ifdef BTN_AUTOREPEAT_EN
      always_ff @(posedge CLK or negedge RESET) begin
         if (!RESET) begin
            rcnt    <= '0;
            rpt_arm <= 1'b0;
         end else begin
            rcnt    <= rcnt_nxt;
            rpt_arm <= rpt_arm_nxt;
         end
      end
`endif

      assign BTN_STATE[i]     = level;
      assign PRESS_PULSE[i]   = press_q;
      assign RELEASE_PULSE[i] = rel_q;
   end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner: stimulus queues expected strobes, a monitor checks them.
// Follows BTN_AUTOREPEAT_EN the same way the design does.
module tb_button_pulse_conditioner;

   logic       CLK;
   logic       RESET;
   logic [1:0] BTN_IN;
   logic [1:0] BTN_STATE;
   logic [1:0] PRESS_PULSE;
   logic [1:0] RELEASE_PULSE;

   typedef struct {
      int         cyc;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] state;
   } exp_t;

   exp_t exp_q[$];
   int   cyc;
   int   n_chk;
   int   n_pass;

   button_pulse_conditioner #(
      .NUM_BTN(2),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .BTN_IN(BTN_IN),
      .BTN_STATE(BTN_STATE),
      .PRESS_PULSE(PRESS_PULSE),
      .RELEASE_PULSE(RELEASE_PULSE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   // Inputs change 2 time units after a falling edge, well away from the active edge.
   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
      #2;
   endtask

   // Debounce of 4 plus the 2-FF synchroniser: strobe visible 6 edges after the input changes.
   task automatic expect_evt(input int lat, input logic [1:0] press, input logic [1:0] rel,
                             input logic [1:0] state);
      exp_t e;
      e.cyc   = cyc + lat;
      e.press = press;
      e.rel   = rel;
      e.state = state;
      exp_q.push_back(e);
   endtask

   task automatic chk_outputs_zero(input string tag);
      #1;
      chk({tag, "_state"}, 32'(BTN_STATE), 32'd0);
      chk({tag, "_press"}, 32'(PRESS_PULSE), 32'd0);
      chk({tag, "_release"}, 32'(RELEASE_PULSE), 32'd0);
   endtask

   always @(negedge CLK) begin : monitor
      exp_t e;
      if ((PRESS_PULSE | RELEASE_PULSE) != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {PRESS_PULSE, RELEASE_PULSE}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            chk("press_pulse", 32'(PRESS_PULSE), 32'(e.press));
            chk("release_pulse", 32'(RELEASE_PULSE), 32'(e.rel));
            chk("btn_state_at_pulse", 32'(BTN_STATE), 32'(e.state));
         end
      end
   end

   initial begin
      n_chk  = 0;
      n_pass = 0;
      RESET  = 1'b1;
      BTN_IN = 2'b11;
      #1 RESET = 1'b0;

      // Reset with both buttons pressed, then release reset and keep holding.
      tick(3);
      chk_outputs_zero("reset");
      tick(1);
      RESET = 1'b1;
      expect_evt(6, 2'b11, 2'b00, 2'b11);
      tick(10);
      BTN_IN = 2'b00;
      expect_evt(6, 2'b00, 2'b11, 2'b00);
      tick(10);

      // Clean press on bit 0, held 20 cycles, then released.
      BTN_IN = 2'b01;
      expect_evt(6, 2'b01, 2'b00, 2'b01);
      tick(20);
      BTN_IN = 2'b00;
      expect_evt(6, 2'b00, 2'b01, 2'b00);
      tick(10);

      // Press bounce shorter than the debounce window.
      BTN_IN = 2'b01;
      tick(3);
      BTN_IN = 2'b00;
      tick(1);
      BTN_IN = 2'b01;
      tick(3);
      BTN_IN = 2'b00;
      tick(12);
      chk("bounce_state", 32'(BTN_STATE), 32'd0);

      // Release bounce on a held bit 1.
      BTN_IN = 2'b10;
      expect_evt(6, 2'b10, 2'b00, 2'b10);
      tick(10);
      BTN_IN = 2'b00;
      tick(2);
      BTN_IN = 2'b10;
      tick(10);
      chk("release_bounce_state", 32'(BTN_STATE), 32'd2);
      BTN_IN = 2'b00;
      expect_evt(6, 2'b00, 2'b10, 2'b00);
      tick(10);

      // Reset two cycles into bit 0 debounce while bit 1 is already held.
      BTN_IN = 2'b10;
      expect_evt(6, 2'b10, 2'b00, 2'b10);
      tick(10);
      BTN_IN = 2'b11;
      tick(4);
      RESET = 1'b0;
      chk_outputs_zero("mid_debounce_reset");
      tick(3);
      RESET = 1'b1;
      expect_evt(6, 2'b11, 2'b00, 2'b11);
      tick(10);
      BTN_IN = 2'b00;
      expect_evt(6, 2'b00, 2'b11, 2'b00);
      tick(10);

      // Long hold on bit 0: auto-repeat strobes only when the macro is defined.
      BTN_IN = 2'b01;
      expect_evt(6, 2'b01, 2'b00, 2'b01);
`ifdef BTN_AUTOREPEAT_EN
      for (int k = 10; k <= 28; k += 3) expect_evt(6 + k, 2'b01, 2'b00, 2'b01);
`endif
      tick(33);
      BTN_IN = 2'b00;
      expect_evt(6, 2'b00, 2'b01, 2'b00);
      tick(15);

      chk("missing_pulses", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
